proteus_pipe_ctrl: RTL

//  Tile sequencer for the Proteus NFU pipeline (SB unpack -> NFU-1 -> NFU-2 -> NFU-3).

---
 rtl/proteus_pipe_ctrl_if.sv | 37 +++
 rtl/proteus_pipe_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/proteus_pipe_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | proteus_pipe_ctrl_if : control/status bundle of the tile sequencer |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
interface proteus_pipe_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             i_start;
  logic [CNT_W-1:0] i_num_in_tiles;
  logic [CNT_W-1:0] i_num_out_tiles;
  logic             i_final;
  logic             i_op;
  logic             i_grp_valid;
  logic             o_data_rd;
  logic [1:0]       o_load_sb;
  logic             o_nbout_rd;
  logic             o_load_nbout;
  logic             o_nbout_nfu2_nfu3;
  logic             o_nbout_wr;
  logic             o_op;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_num_in_tiles, i_num_out_tiles, i_final, i_op, i_grp_valid,
    input  o_data_rd, o_load_sb, o_nbout_rd, o_load_nbout, o_nbout_nfu2_nfu3,
    input  o_nbout_wr, o_op, o_busy, o_done
  );

  modport slave (
    input  i_start, i_num_in_tiles, i_num_out_tiles, i_final, i_op, i_grp_valid,
    output o_data_rd, o_load_sb, o_nbout_rd, o_load_nbout, o_nbout_nfu2_nfu3,
    output o_nbout_wr, o_op, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/proteus_pipe_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | proteus_pipe_ctrl : NFU tile sequencer with latency-matched strobes |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module proteus_pipe_ctrl #(
  parameter int NFU1_LAT = 3,
  parameter int NFU2_LAT = 2,
  parameter int NFU3_LAT = 2,
  parameter int CNT_W    = 8
) (
  input  wire logic          clk,
  input  wire logic          i_rst_n,
  proteus_pipe_ctrl_if.slave bus
);
  localparam int C_FIRST_D = NFU1_LAT + 1;
  localparam int C_LAST_D  = NFU1_LAT + 1 + NFU2_LAT + NFU3_LAT;
  localparam int C_WR_NF   = NFU1_LAT + NFU2_LAT;
  localparam int C_WR_F    = NFU1_LAT + NFU2_LAT + NFU3_LAT;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_num_in;
  logic [CNT_W-1:0]     r_num_out;
  logic                 r_final;
  logic                 r_op;
  logic [CNT_W-1:0]     r_in_cnt;
  logic [CNT_W-1:0]     r_out_cnt;
  logic [C_FIRST_D-1:0] r_first_sr;
  logic [C_LAST_D-1:0]  r_last_sr;

  logic w_issue;
  logic w_first;
  logic w_last;
  logic w_run_end;
  logic w_wr;
  logic w_pend;

  assign w_issue   = (r_state == S_ISSUE);
  assign w_first   = (r_in_cnt == '0);
  assign w_last    = (r_in_cnt == r_num_in - CNT_W'(1));
  assign w_run_end = (r_out_cnt == r_num_out - CNT_W'(1));
  assign w_wr      = r_final ? r_last_sr[C_WR_F] : r_last_sr[C_WR_NF];

  // Younger last-tokens still in flight mean this write is not the final one.
  always_comb begin
    w_pend = 1'b0;
    for (int k = 0; k < C_LAST_D; k++) begin
      if (k < (r_final ? C_WR_F : C_WR_NF)) begin
        w_pend = w_pend | r_last_sr[k];
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_CFG;
      S_CFG: begin
        if ((r_num_in == '0) || (r_num_out == '0)) begin
          w_state_nxt = S_DONE;
        end else if (bus.i_grp_valid) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT:  if (bus.i_grp_valid) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_last) w_state_nxt = w_run_end ? S_DRAIN : S_WAIT;
      S_DRAIN: if (w_wr && !w_pend) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num_in  <= '0;
      r_num_out <= '0;
      r_final   <= 1'b0;
      r_op      <= 1'b0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (bus.i_start) begin
        r_num_in  <= bus.i_num_in_tiles;
        r_num_out <= bus.i_num_out_tiles;
        r_final   <= bus.i_final;
        r_op      <= bus.i_op;
      end
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_issue) begin
      if (w_last) begin
        r_in_cnt  <= '0;
        r_out_cnt <= r_out_cnt + CNT_W'(1);
      end else begin
        r_in_cnt <= r_in_cnt + CNT_W'(1);
      end
    end
  end

  // Token delay lines: bit k holds a token issued k+1 cycles ago.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_first_sr <= '0;
      r_last_sr  <= '0;
    end else begin
      r_first_sr <= {r_first_sr[C_FIRST_D-2:0], w_issue & w_first};
      r_last_sr  <= {r_last_sr[C_LAST_D-2:0], w_issue & w_last};
    end
  end

  assign bus.o_data_rd         = w_issue;
  assign bus.o_load_sb         = (r_state == S_CFG) ? 2'b11 : 2'b00;
  assign bus.o_nbout_rd        = r_first_sr[NFU1_LAT-1];
  assign bus.o_load_nbout      = r_first_sr[NFU1_LAT];
  assign bus.o_nbout_wr        = w_wr;
  assign bus.o_nbout_nfu2_nfu3 = w_wr & ~r_final;
  assign bus.o_op              = r_op;
  assign bus.o_busy            = (r_state != S_IDLE);
  assign bus.o_done            = (r_state == S_DONE);
endmodule
`default_nettype wire
